// File: rtl/fnd_scan_rx.sv
// fnd_scan_rx: receive side of the multiplexed 7-segment scan bus.
// Registers the scanned bus, waits for a stable sample on one enabled digit,
// reverses the segment encoding and keeps per-digit codes, decimal points and
// validity, plus frame-complete, error and stall indications.
module fnd_scan_rx #(
    parameter int DIGITS  = 6,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            i_seg,
    input  logic                  i_seg_dp,
    input  logic [DIGITS-1:0]     i_seg_enb,
    input  logic                  i_clr,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic [DIGITS-1:0]     o_dp,
    output logic [DIGITS-1:0]     o_valid,
    output logic                  o_frame_done,
    output logic                  o_err,
    output logic [7:0]            o_err_cnt,
    output logic                  o_stall
);

    localparam int SW  = $clog2(SETTLE + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int SMP = DIGITS + 8;
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
    localparam logic [TW-1:0] TMO_C    = TW'(TIMEOUT);
    localparam logic [SW-1:0] ONE_C    = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Reverse segment decode: returns {legal, code}; blank is legal code F.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   seg_decode = 5'b1_0000;
            7'h30:   seg_decode = 5'b1_0001;
            7'h6D:   seg_decode = 5'b1_0010;
            7'h79:   seg_decode = 5'b1_0011;
            7'h33:   seg_decode = 5'b1_0100;
            7'h5B:   seg_decode = 5'b1_0101;
            7'h5F:   seg_decode = 5'b1_0110;
            7'h70:   seg_decode = 5'b1_0111;
            7'h7F:   seg_decode = 5'b1_1000;
            7'h73:   seg_decode = 5'b1_1001;
            7'h00:   seg_decode = 5'b1_1111;
            default: seg_decode = 5'b0_1110;
        endcase
    endfunction

    logic                  sync_rst_s;
    logic [6:0]            s_seg_r;
    logic                  s_dp_r;
    logic [DIGITS-1:0]     s_enb_r;
    logic [SMP-1:0]        prev_r;
    logic [SMP-1:0]        cur_s;
    logic [DIGITS-1:0]     enb_low_s;
    logic                  idle_s;
    logic                  onehot_s;
    logic                  multi_s;
    logic                  multi_r;
    logic                  changed_s;
    state_t                state_r;
    state_t                state_next_s;
    logic [SW-1:0]         stab_r;
    logic [SW-1:0]         stab_next_s;
    logic [SW-1:0]         stab_inc_s;
    logic                  cap_s;
    logic [4:0]            dec_s;
    logic                  err_evt_s;
    logic [DIGITS-1:0]     mask_r;
    logic [DIGITS-1:0]     mask_next_s;
    logic [TW-1:0]         tmo_r;
    logic [TW-1:0]         tmo_next_s;
    logic [4*DIGITS-1:0]   digits_r;
    logic [DIGITS-1:0]     dp_r;
    logic [DIGITS-1:0]     valid_r;
    logic                  frame_done_r;
    logic                  err_r;
    logic [7:0]            err_cnt_r;
    logic                  stall_r;

    assign sync_rst_s = rst | i_clr;

    // Input stage: one register on the scan bus; prev_r holds the sample before it.
    always_ff @(posedge clk) begin
        if (sync_rst_s) begin
            s_seg_r <= 7'h00;
            s_dp_r  <= 1'b0;
            s_enb_r <= {DIGITS{1'b1}};
            prev_r  <= {{DIGITS{1'b1}}, 8'h00};
        end else begin
            s_seg_r <= i_seg;
            s_dp_r  <= i_seg_dp;
            s_enb_r <= i_seg_enb;
            prev_r  <= cur_s;
        end
    end

    // Enable classification, sample comparison and segment decode.
    always_comb begin
        cur_s       = {s_enb_r, s_seg_r, s_dp_r};
        changed_s   = (cur_s != prev_r);
        enb_low_s   = ~s_enb_r;
        idle_s      = (enb_low_s == {DIGITS{1'b0}});
        onehot_s    = !idle_s && ((enb_low_s & (enb_low_s - DIGITS'(1))) == {DIGITS{1'b0}});
        multi_s     = !idle_s && !onehot_s;
        dec_s       = seg_decode(s_seg_r);
        mask_next_s = mask_r | enb_low_s;
        stab_inc_s  = changed_s ? ONE_C : (stab_r + ONE_C);
    end

    // Next state and capture decision; multi-enable and idle override everything.
    always_comb begin
        state_next_s = state_r;
        stab_next_s  = stab_r;
        cap_s        = 1'b0;
        if (multi_s || idle_s) begin
            state_next_s = ST_IDLE;
            stab_next_s  = {SW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stab_next_s = ONE_C;
                    if (ONE_C == SETTLE_C) begin
                        cap_s        = 1'b1;
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    stab_next_s = stab_inc_s;
                    if (stab_inc_s == SETTLE_C) begin
                        cap_s        = 1'b1;
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_HOLD: begin
                    if (!changed_s) begin
                        state_next_s = ST_HOLD;
                    end else if (ONE_C == SETTLE_C) begin
                        stab_next_s  = ONE_C;
                        cap_s        = 1'b1;
                        state_next_s = ST_HOLD;
                    end else begin
                        stab_next_s  = ONE_C;
                        state_next_s = ST_SETTLE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    stab_next_s  = {SW{1'b0}};
                end
            endcase
        end
        err_evt_s  = (multi_s && !multi_r) || (cap_s && !dec_s[4]);
        tmo_next_s = cap_s ? {TW{1'b0}} : ((tmo_r == TMO_C) ? tmo_r : (tmo_r + TW'(1)));
    end

    // FSM state, stability counter and multi-enable history.
    always_ff @(posedge clk) begin
        if (sync_rst_s) begin
            state_r <= ST_IDLE;
            stab_r  <= {SW{1'b0}};
            multi_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            stab_r  <= stab_next_s;
            multi_r <= multi_s;
        end
    end

    // Captured digit data; only the single enabled digit is written.
    always_ff @(posedge clk) begin
        if (sync_rst_s) begin
            digits_r <= {DIGITS{4'hF}};
            dp_r     <= {DIGITS{1'b0}};
            valid_r  <= {DIGITS{1'b0}};
        end else if (cap_s) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (enb_low_s[k]) begin
                    digits_r[4*k +: 4] <= dec_s[3:0];
                    dp_r[k]            <= s_dp_r;
                    valid_r[k]         <= dec_s[4];
                end
            end
        end
    end

    // Frame mask, error pulse/count and stall timeout.
    always_ff @(posedge clk) begin
        if (sync_rst_s) begin
            mask_r       <= {DIGITS{1'b0}};
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            err_cnt_r    <= 8'h00;
            tmo_r        <= {TW{1'b0}};
            stall_r      <= 1'b0;
        end else begin
            err_r   <= err_evt_s;
            tmo_r   <= tmo_next_s;
            stall_r <= (tmo_next_s == TMO_C);
            if (err_evt_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'h01;
            end
            if (cap_s && (mask_next_s == {DIGITS{1'b1}})) begin
                frame_done_r <= 1'b1;
                mask_r       <= {DIGITS{1'b0}};
            end else if (cap_s) begin
                frame_done_r <= 1'b0;
                mask_r       <= mask_next_s;
            end else begin
                frame_done_r <= 1'b0;
            end
        end
    end

    assign o_digits     = digits_r;
    assign o_dp         = dp_r;
    assign o_valid      = valid_r;
    assign o_frame_done = frame_done_r;
    assign o_err        = err_r;
    assign o_err_cnt    = err_cnt_r;
    assign o_stall      = stall_r;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Directed bench for fnd_scan_rx with hand-computed expectations.
module tb_fnd_scan_rx;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic        i_clr;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_valid;
    logic        o_frame_done;
    logic        o_err;
    logic [7:0]  o_err_cnt;
    logic        o_stall;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_frame = 0;
    int n_err   = 0;
    int base_frame;
    int base_err;

    fnd_scan_rx #(.DIGITS(6), .SETTLE(3), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
        .i_seg_enb(i_seg_enb), .i_clr(i_clr), .o_digits(o_digits),
        .o_dp(o_dp), .o_valid(o_valid), .o_frame_done(o_frame_done),
        .o_err(o_err), .o_err_cnt(o_err_cnt), .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    // Count output pulses between clock edges.
    always @(negedge clk) begin
        if (o_frame_done) n_frame = n_frame + 1;
        if (o_err)        n_err   = n_err + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp);
        i_seg_enb = enb;
        i_seg     = seg;
        i_seg_dp  = dp;
    endtask

    task automatic pulse_clr();
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
    endtask

    logic [6:0] t1_seg [6];
    logic [5:0] en;

    initial begin
        t1_seg = '{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h73};
        rst = 1'b1;
        i_clr = 1'b0;
        drive(6'b111111, 7'h00, 1'b0);
        step(2);
        rst = 1'b0;
        check_eq("rst_digits", o_digits, 32'h00FFFFFF);
        check_eq("rst_dp", o_dp, 32'h0);
        check_eq("rst_valid", o_valid, 32'h0);
        check_eq("rst_flags", {o_frame_done, o_err, o_stall}, 32'h0);
        check_eq("rst_errcnt", o_err_cnt, 32'h0);

        // Full frame 1,2,3,4,5,9 with dp on digit 2
        base_frame = n_frame;
        base_err   = n_err;
        for (int k = 0; k < 5; k++) begin
            en = ~(6'b000001 << k);
            drive(en, t1_seg[k], (k == 2));
            step(8);
        end
        drive(6'b011111, t1_seg[5], 1'b0);
        step(3);
        check_eq("f_d5_pre", o_digits[23:20], 32'hF);
        check_eq("f_done_pre", o_frame_done, 32'h0);
        step(1);
        check_eq("f_done_pulse", o_frame_done, 32'h1);
        check_eq("f_digits", o_digits, 32'h00954321);
        step(4);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);
        check_eq("f_dp", o_dp, 32'h04);
        check_eq("f_valid", o_valid, 32'h3F);
        check_eq("f_nframe", n_frame - base_frame, 32'd1);
        check_eq("f_nerr", n_err - base_err, 32'd0);
        check_eq("f_errcnt", o_err_cnt, 32'h0);

        // Clear, then a glitch shorter than SETTLE followed by a stable 1
        pulse_clr();
        check_eq("clr_digits", o_digits, 32'h00FFFFFF);
        check_eq("clr_valid", o_valid, 32'h0);
        drive(6'b111110, 7'h7E, 1'b0);
        step(2);
        drive(6'b111110, 7'h30, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            step(1);
            check_eq("s_d0_hold", o_digits[3:0], 32'hF);
        end
        step(1);
        check_eq("s_d0_cap", o_digits[3:0], 32'h1);
        check_eq("s_valid", o_valid, 32'h01);
        step(4);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);

        // Illegal pattern on digit 3
        base_err = n_err;
        drive(6'b110111, 7'h7C, 1'b0);
        step(4);
        check_eq("i_err_pulse", o_err, 32'h1);
        check_eq("i_d3", o_digits[15:12], 32'hE);
        step(1);
        check_eq("i_err_end", o_err, 32'h0);
        step(3);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);
        check_eq("i_valid", o_valid, 32'h01);
        check_eq("i_errcnt", o_err_cnt, 32'd1);
        check_eq("i_nerr", n_err - base_err, 32'd1);
        check_eq("i_digits", o_digits, 32'h00FFEFF1);

        // Multi-enable held for 10 cycles
        base_err = n_err;
        drive(6'b111100, 7'h30, 1'b0);
        step(10);
        check_eq("m_errcnt", o_err_cnt, 32'd2);
        check_eq("m_nerr", n_err - base_err, 32'd1);
        check_eq("m_digits", o_digits, 32'h00FFEFF1);
        check_eq("m_valid", o_valid, 32'h01);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);
        drive(6'b111011, 7'h5F, 1'b1);
        step(4);
        check_eq("m_after_cap", o_digits, 32'h00FFE6F1);
        check_eq("m_after_dp", o_dp, 32'h04);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);

        // Stall after TIMEOUT idle cycles, cleared by the next capture
        pulse_clr();
        step(TMO - 1);
        check_eq("t_stall_pre", o_stall, 32'h0);
        step(1);
        check_eq("t_stall_set", o_stall, 32'h1);
        drive(6'b101111, 7'h33, 1'b0);
        step(3);
        check_eq("t_stall_hold", o_stall, 32'h1);
        step(1);
        check_eq("t_stall_clr", o_stall, 32'h0);
        check_eq("t_digits", o_digits, 32'h00F4FFFF);
        check_eq("t_valid", o_valid, 32'h10);
        drive(6'b111111, 7'h00, 1'b0);
        step(2);

        // Reset in the middle of SETTLE, one edge before capture
        drive(6'b111101, 7'h6D, 1'b1);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drive(6'b111111, 7'h00, 1'b0);
        check_eq("r_digits", o_digits, 32'h00FFFFFF);
        check_eq("r_dp", o_dp, 32'h0);
        check_eq("r_valid", o_valid, 32'h0);
        check_eq("r_flags", {o_frame_done, o_err, o_stall}, 32'h0);
        check_eq("r_errcnt", o_err_cnt, 32'h0);
        step(6);
        check_eq("r_no_cap_valid", o_valid, 32'h0);
        check_eq("r_no_cap_digits", o_digits, 32'h00FFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_rx.md
Name: fnd_scan_rx

Overview:
- Receive-side counterpart of the multiplexed six-digit 7-segment scan driver.
- Samples the scanned segment bus, digit-enable bus and decimal-point line, and reconstructs the per-digit BCD values and decimal points. This reverses the segment encoding.
- Used as an in-design readback/monitor of the display path and as the checker front-end in display-level benches.
- Flags illegal segment patterns and multi-digit enables, signals completion of each full scan frame, and signals a stalled scan.

Parameters:
- DIGITS, 6, number of scanned digits (enable bus width).
- SETTLE, 3, consecutive identical samples required before a digit is captured (min 1).
- TIMEOUT, 20000, cycles without any capture before o_stall asserts.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- i_seg, input, 7, segment bus {a,b,c,d,e,f,g}, active-high.
- i_seg_dp, input, 1, decimal point of the currently enabled digit.
- i_seg_enb, input, DIGITS, digit enables, active-low, one-hot-low when driving.
- i_clr, input, 1, synchronous clear of captured data, error and frame state.
- o_digits, output, 4*DIGITS, captured codes; digit k in bits [4k+3:4k].
- o_dp, output, DIGITS, captured decimal points.
- o_valid, output, DIGITS, digit k has been captured with a legal pattern since the last reset/clear.
- o_frame_done, output, 1, one-cycle pulse when every digit has been captured since the previous pulse.
- o_err, output, 1, one-cycle pulse on an illegal pattern or multi-enable.
- o_err_cnt, output, 8, saturating error count.
- o_stall, output, 1, level; no capture for TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_digits = all 4'hF; o_dp = 0; o_valid = 0.
  - o_frame_done = 0, o_err = 0, o_err_cnt = 0, o_stall = 0.
  - Internal state returns to IDLE; stability counter, frame mask and timeout counter are cleared.
  - Reset mid-capture discards the partial sample.
- i_clr has the same effect as rst.
- Input stage:
  - i_seg, i_seg_dp and i_seg_enb are registered once into s_seg, s_dp, s_enb.
  - All decisions use the registered values.
- Enable decode on s_enb:
  - All ones = idle.
  - Exactly one zero at bit k = digit k.
  - Two or more zeros = multi-enable.
- State machine:
  - IDLE: s_enb idle. Go to SETTLE when exactly one bit is low; stab_cnt=1.
  - SETTLE: stab_cnt increments while {s_enb,s_seg,s_dp} equals the previous sample.
    - Any change restarts stab_cnt=1 and stays in SETTLE (or goes to IDLE if idle).
    - When stab_cnt reaches SETTLE, capture digit k and go to HOLD.
  - HOLD: no further capture. Any change in {s_enb,s_seg,s_dp} goes to SETTLE (stab_cnt=1), or to IDLE if idle.
  - Multi-enable from any state: go to IDLE, pulse o_err once per entry into the condition, increment o_err_cnt, no capture.
- Capture latency: the new o_digits/o_dp/o_valid values are visible SETTLE+1 clk edges after the inputs first present the stable value.
- Reverse decode of s_seg:
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 73->9 (hex): code = digit, o_valid[k]=1.
  - 00: code = 4'hF (blank), o_valid[k]=1.
  - Any other pattern: code = 4'hE, o_valid[k]=0, o_err pulse, o_err_cnt++.
- o_dp[k] takes s_dp at capture.
- o_err_cnt saturates at 255.
- Frame tracking:
  - A DIGITS-bit mask sets bit k on each capture, legal or not.
  - When a capture makes the mask all ones, o_frame_done pulses in the same cycle that the capture lands, and the mask clears.
  - Re-capturing an already-set digit only updates data; it does not restart the frame.
- Timeout:
  - The counter clears on every capture and increments otherwise, saturating at TIMEOUT.
  - o_stall = 1 while the counter equals TIMEOUT; it drops on the capture edge.
- Simultaneous events:
  - rst/i_clr have priority over everything.
  - An illegal-pattern capture that completes a frame pulses both o_err and o_frame_done.

Test Plan:
- Drive digits 0..5 showing 1,2,3,4,5,9 (30,6D,79,33,5B,73), dp only on digit 2, each held 8 cycles, enb 111110..011111 -> o_digits=0x954321, o_dp=000100, o_valid=111111, one o_frame_done pulse on the digit-5 capture, o_err=0.
- Hold digit 0 = 7E for exactly SETTLE-1 (=2) cycles, then change to 30 for 8 cycles -> only code 1 is captured, 4 edges after 30 first appears.
- Digit 3 segment bus = 0x7C (illegal) for 8 cycles -> o_digits[15:12]=4'hE, o_valid[3]=0, one o_err pulse, o_err_cnt=1.
- i_seg_enb=111100 for 10 cycles -> one o_err pulse, o_err_cnt increments by 1, no o_digits change, state returns to IDLE.
- Enables idle (all ones) for TIMEOUT cycles -> o_stall=1. The next valid capture clears it; o_stall=0 on that edge.
- Assert rst mid-SETTLE after 2 stable cycles -> all outputs at reset values; no capture of the interrupted digit.
